serial_adder: RTL
=================

# serial_adder

Bit-serial WIDTH-bit adder built around one full-adder cell and a carry flip-flop; it is the addition counterpart of the team's 1-bit borrow-chain subtractor cells. Operands are captured on a start handshake and summed LSB-first, one bit per clock. The result, carry-out and signed overflow are presented with a one-cycle done pulse. It sits in the ALU datapath as the area-minimal ADD path.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 2 to 32.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a new addition; sampled only when the block accepts (see Operation).
- a  input  WIDTH  augend, captured on the accepting edge.
- b  input  WIDTH  addend, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset (rst_n=0 at an edge) puts the FSM in IDLE and clears all outputs and internal registers: busy=0, done=0, sum=0, cout=0, overflow=0, carry=0, count=0.
- Reset is honoured mid-operation: an in-flight addition is abandoned and produces no done pulse.
- Reset has priority over start.
- IDLE:
  - start=1 is accepted.
  - On acceptance, a, b and cin are latched into shift registers A, B and a carry flip-flop, count is set to 0, and the FSM moves to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN, at each edge:
  - s = A[0]^B[0]^carry, and carry becomes majority(A[0],B[0],carry).
  - s is shifted into the MSB of the internal result shift register.
  - A and B shift right, and count increments.
  - On the edge where count equals WIDTH-1 (the last bit), the FSM goes to DONE. On that same edge it loads sum from the completed shift register, loads cout with the new carry, and loads overflow with (carry into bit WIDTH-1) XOR (new carry).
- start is ignored in RUN: no abort and no re-latch.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation), and the FSM goes to RUN. Otherwise it goes to IDLE.
- Result holding: sum, cout and overflow hold their value until the next completion or a reset. They do not change during RUN.
- Arithmetic is unsigned modulo 2^WIDTH. cout and overflow together support both unsigned and signed interpretation.

## Timing
- Start sampled at edge k:
  - busy=1 after edges k through k+WIDTH-1.
  - Results update and done=1 after edge k+WIDTH.
  - Latency is WIDTH edges from the accepting edge to done.
- Throughput: one addition per WIDTH+1 cycles when start is held high continuously. The next start is accepted at edge k+WIDTH+1, in the DONE cycle.
- busy and done are never high in the same cycle.
- Operand inputs may change freely after the accepting edge.

## Test plan
- Reset, then a=8'h35, b=8'h4A, cin=0, one-cycle start → done exactly 8 edges later with sum=8'h7F, cout=0, overflow=0. busy is high for 8 cycles.
- Unsigned wrap: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, overflow=0. Also a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1.
- Signed overflow: a=8'h7F, b=8'h01 → sum=8'h80, cout=0, overflow=1. Also a=8'h80, b=8'h80 → sum=8'h00, cout=1, overflow=1.
- Start pulsed mid-RUN with different operands → ignored; the original result is delivered on schedule and no extra done pulse follows.
- rst_n=0 for one edge at RUN cycle 4 → next cycle shows busy=0, done=0, sum=0, cout=0, overflow=0, and no done pulse appears afterwards.
- start held high with new operands in the DONE cycle → second result (8'h10+8'h20=8'h30) appears 9 cycles after the first done. The first result holds during the second RUN.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Operands are latched on start; sum, cout and overflow are registered and held until the next done.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  count_q, count_d;

  logic bit_s;
  logic carry_new;
  logic last_bit;
  logic accept;

  assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_new = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit  = (count_q == CntW'(WIDTH - 1));
  // Start is honoured in DONE as well as IDLE so back-to-back adds lose no cycle.
  assign accept    = start && (state_q == StIdle || state_q == StDone);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      count_d = '0;
    end else if (state_q == StRun) begin
      res_d   = {bit_s, res_q[WIDTH-1:1]};
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = carry_new;
      count_d = count_q + CntW'(1);
      if (last_bit) begin
        sum_d  = {bit_s, res_q[WIDTH-1:1]};
        cout_d = carry_new;
        // carry_q is the carry into the MSB on the last bit.
        ovf_d  = carry_q ^ carry_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
